// File: rtl/fetch_pkg.sv
// Purpose: shared types, counter constants and helpers for the fetch predictor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

    // 2-bit saturating branch counter; MSB set means "predict taken"
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;   // strongly not taken
    localparam ctr_t CTR_WNT = 2'd1;   // weakly not taken
    localparam ctr_t CTR_WT  = 2'd2;   // weakly taken
    localparam ctr_t CTR_ST  = 2'd3;   // strongly taken

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // The tag field is sized for the smallest legal index width; narrower
    // tags are stored zero-extended so one struct serves every IDX_W.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;   // word-aligned target, pc[31:2]
        ctr_t        ctr;
    } btb_entry_t;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/btb_table.sv
// Purpose: direct-mapped BTB storage with combinational lookup and one training write port.
// Latency: lookup is combinational; writes are visible the cycle after they are presented.
// Backpressure: none; a write is accepted every cycle wr_en is high (reset blocks it).
// Ports: clk/reset; rd_pc -> rd_hit/rd_taken/rd_target; wr_en/wr_pc/wr_taken/wr_target train one entry.
module btb_table
    import fetch_pkg::*;
#(
    parameter int   IDX_W     = 6,
    parameter ctr_t ALLOC_CTR = CTR_WT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd_pc,
    output logic        rd_hit,
    output logic        rd_taken,
    output logic [31:0] rd_target,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic        wr_taken,
    input  logic [31:0] wr_target
);

    localparam int ENTRIES = 2 ** IDX_W;

    function automatic logic [29:0] tag_of(input logic [31:0] pc);
        return 30'(pc >> (IDX_W + 2));
    endfunction

    // Only valid bits are reset; tag/target/ctr are qualified by valid.
    logic [ENTRIES-1:0] valid_q;
    logic [29:0]        tag_q    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    btb_entry_t       rd_e;
    btb_entry_t       wr_e;
    logic             wr_hit;

    // Byte-offset bits never address the table.
    logic unused_bits;
    assign unused_bits = ^{rd_pc[1:0], wr_pc[1:0], wr_target[1:0]};

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign wr_idx = wr_pc[IDX_W+1:2];

    always_comb begin
        rd_e = '{valid: valid_q[rd_idx], tag: tag_q[rd_idx],
                 target: target_q[rd_idx], ctr: ctr_q[rd_idx]};
        wr_e = '{valid: valid_q[wr_idx], tag: tag_q[wr_idx],
                 target: target_q[wr_idx], ctr: ctr_q[wr_idx]};
    end

    assign rd_hit    = rd_e.valid && (rd_e.tag == tag_of(rd_pc));
    assign rd_taken  = rd_hit && rd_e.ctr[1];
    assign rd_target = rd_hit ? {rd_e.target, 2'b00} : 32'h0;
    assign wr_hit    = wr_e.valid && (wr_e.tag == tag_of(wr_pc));

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= wr_taken ? sat_inc(wr_e.ctr) : sat_dec(wr_e.ctr);
                if (wr_taken) begin
                    target_q[wr_idx] <= wr_target[31:2];
                end
            end else if (wr_taken) begin
                // Taken miss replaces whatever lived at this index (aliases included).
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= tag_of(wr_pc);
                target_q[wr_idx] <= wr_target[31:2];
                ctr_q[wr_idx]    <= ALLOC_CTR;
            end
        end
    end

endmodule

// File: rtl/fetch_predictor.sv
// Purpose: fetch PC register, next-PC selection and BTB-based taken prediction.
// Latency: prediction is combinational on pcF; redirect appears on the next pcF.
// Backpressure: stallF holds pcF; mispredict overrides the stall; training ignores both.
// Ports: clk/reset; stallF; pcF/predTakenF/predTargetF; upd* from EX; mispredict/redirectPc.
// Optional: define FETCH_STATS_EN to add saturating statLookups/statPredTaken/statMispredicts.
module fetch_predictor
    import fetch_pkg::*;
#(
    parameter int          IDX_W     = 6,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [1:0]  ALLOC_CTR = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    output logic [31:0] pcF,
    output logic        predTakenF,
    output logic [31:0] predTargetF,
    input  logic        updEn,
    input  logic [31:0] updPc,
    input  logic        updTaken,
    input  logic [31:0] updTarget,
    input  logic        mispredict,
    input  logic [31:0] redirectPc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] statLookups,
    output logic [31:0] statPredTaken,
    output logic [31:0] statMispredicts
`endif
);

    logic        pred_hit;
    logic [31:0] pc_next;

    btb_table #(
        .IDX_W     (IDX_W),
        .ALLOC_CTR (ALLOC_CTR)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (pcF),
        .rd_hit    (pred_hit),
        .rd_taken  (predTakenF),
        .rd_target (predTargetF),
        .wr_en     (updEn),
        .wr_pc     (updPc),
        .wr_taken  (updTaken),
        .wr_target (updTarget)
    );

    // A hit with a not-taken counter still falls through to pc+4.
    logic unused_hit;
    assign unused_hit = pred_hit;

    always_comb begin
        pc_next = pcF + 32'd4;
        if (mispredict) begin
            pc_next = redirectPc;
        end else if (stallF) begin
            pc_next = pcF;
        end else if (predTakenF) begin
            pc_next = predTargetF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcF <= RESET_PC;
        end else begin
            pcF <= pc_next;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            statLookups     <= '0;
            statPredTaken   <= '0;
            statMispredicts <= '0;
        end else begin
            if (!stallF && statLookups != 32'hFFFF_FFFF) begin
                statLookups <= statLookups + 32'd1;
            end
            if (predTakenF && !stallF && statPredTaken != 32'hFFFF_FFFF) begin
                statPredTaken <= statPredTaken + 32'd1;
            end
            if (mispredict && statMispredicts != 32'hFFFF_FFFF) begin
                statMispredicts <= statMispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_predictor.sv
// Purpose: directed and randomized checks of fetch_predictor against a behavioural model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: stallF and mispredict are exercised both directed and randomly.
module tb_fetch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stallF = 1'b0;
    logic [31:0] pcF;
    logic        predTakenF;
    logic [31:0] predTargetF;
    logic        updEn = 1'b0;
    logic [31:0] updPc = '0;
    logic        updTaken = 1'b0;
    logic [31:0] updTarget = '0;
    logic        mispredict = 1'b0;
    logic [31:0] redirectPc = '0;
`ifdef FETCH_STATS_EN
    logic [31:0] statLookups, statPredTaken, statMispredicts;
`endif

    always #5 clk = ~clk;

    fetch_predictor dut (
        .clk         (clk),
        .reset       (reset),
        .stallF      (stallF),
        .pcF         (pcF),
        .predTakenF  (predTakenF),
        .predTargetF (predTargetF),
        .updEn       (updEn),
        .updPc       (updPc),
        .updTaken    (updTaken),
        .updTarget   (updTarget),
        .mispredict  (mispredict),
        .redirectPc  (redirectPc)
`ifdef FETCH_STATS_EN
        ,
        .statLookups     (statLookups),
        .statPredTaken   (statPredTaken),
        .statMispredicts (statMispredicts)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: 64 slots keyed by word index, tag = pc / 256.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    logic [31:0] m_pc;
    longint      m_lk, m_pt, m_mis;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 256);
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[slot(pc)] : 32'h0;
    endfunction

    function automatic longint bump(input longint v);
        return (v >= 64'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic step(input bit rst, input bit stall, input bit ue, input logic [31:0] up,
                        input bit ut, input logic [31:0] utg, input bit mp, input logic [31:0] rp);
        bit          lt;
        logic [31:0] ltg;
        int          s;
        reset = rst; stallF = stall; updEn = ue; updPc = up; updTaken = ut;
        updTarget = utg; mispredict = mp; redirectPc = rp;

        if (rst) begin
            m_pc = 32'h0;
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_lk = 0; m_pt = 0; m_mis = 0;
        end else begin
            lt  = m_taken(m_pc);
            ltg = m_target(m_pc);
            if (!stall) m_lk = bump(m_lk);
            if (lt && !stall) m_pt = bump(m_pt);
            if (mp) m_mis = bump(m_mis);
            if (ue) begin
                s = slot(up);
                if (m_hit(up)) begin
                    if (ut) begin
                        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_tgt[s] = utg & 32'hFFFF_FFFC;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (ut) begin
                    m_valid[s] = 1'b1;
                    m_tag[s]   = up / 256;
                    m_tgt[s]   = utg & 32'hFFFF_FFFC;
                    m_ctr[s]   = 2;
                end
            end
            if (mp)         m_pc = rp;
            else if (stall) m_pc = m_pc;
            else if (lt)    m_pc = ltg;
            else            m_pc = m_pc + 32'd4;
        end

        @(posedge clk);
        #1;
        chk("pcF", pcF, m_pc);
        chk("predTakenF", {31'b0, predTakenF}, {31'b0, m_taken(m_pc)});
        chk("predTargetF", predTargetF, m_target(m_pc));
`ifdef FETCH_STATS_EN
        chk("statLookups", statLookups, m_lk[31:0]);
        chk("statPredTaken", statPredTaken, m_pt[31:0]);
        chk("statMispredicts", statMispredicts, m_mis[31:0]);
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic redir(input logic [31:0] pc);
        step(0, 0, 0, 32'h0, 0, 32'h0, 1, pc);
    endtask

    // Counter training at 0x40 starting from the allocated weakly-taken state.
    bit train_tk  [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    bit train_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        logic [31:0] up, rp, utg;

        // Reset, then sequential fetch.
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        chk("rst_pc", pcF, 32'h0);
        chk("rst_pred", {31'b0, predTakenF}, 32'h0);
        idle(); chk("seq_pc4", pcF, 32'h4);
        idle(); chk("seq_pc8", pcF, 32'h8);
        chk("seq_pred", {31'b0, predTakenF}, 32'h0);

        // Allocate 0x40 -> 0x100 while redirecting fetch onto it.
        step(0, 0, 1, 32'h40, 1, 32'h100, 1, 32'h40);
        chk("alloc_pred", {31'b0, predTakenF}, 32'h1);
        chk("alloc_tgt", predTargetF, 32'h100);
        idle(); chk("follow_tgt", pcF, 32'h100);

        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 32'h40, train_tk[i], 32'h100, 1, 32'h40);
            chk($sformatf("train%0d", i), {31'b0, predTakenF}, {31'b0, train_exp[i]});
        end

        // Alias at the same index replaces the 0x40 entry.
        step(0, 0, 1, 32'h140, 1, 32'h200, 1, 32'h40);
        chk("alias_old_pred", {31'b0, predTakenF}, 32'h0);
        chk("alias_old_tgt", predTargetF, 32'h0);
        redir(32'h140);
        chk("alias_new_tgt", predTargetF, 32'h200);

        // Mispredict overrides stall, then stall holds.
        step(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h80);
        chk("misp_over_stall", pcF, 32'h80);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0); chk("stall_hold1", pcF, 32'h80);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0); chk("stall_hold2", pcF, 32'h80);

        // Lookup during a same-index update sees the old contents.
        chk("pre_upd_pred", {31'b0, predTakenF}, 32'h0);
        step(0, 1, 1, 32'h80, 1, 32'h300, 0, 32'h0);
        chk("post_upd_pred", {31'b0, predTakenF}, 32'h1);
        idle(); chk("post_upd_pc", pcF, 32'h300);

        // PC wraps past the top of the address space.
        redir(32'hFFFF_FFFC);
        idle(); chk("wrap_pc", pcF, 32'h0);

        // Reset wins over a concurrent allocation and clears existing entries.
        step(1, 0, 1, 32'h44, 1, 32'h400, 0, 32'h0);
        chk("rst_upd_pc", pcF, 32'h0);
        redir(32'h80); chk("rst_clear_80", {31'b0, predTakenF}, 32'h0);
        redir(32'h44); chk("rst_no_alloc", {31'b0, predTakenF}, 32'h0);

        // Randomized traffic in a small window so aliases and hits are frequent.
        for (int n = 0; n < 3000; n++) begin
            rp  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            utg = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            up  = ($urandom % 2 == 0) ? m_pc : {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            step($urandom_range(0, 199) == 0, $urandom % 5 == 0, $urandom % 2 == 0, up,
                 $urandom % 3 != 0, utg, $urandom % 8 == 0, rp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_predictor.md
Name: fetch_predictor

Overview:
IF-stage block that owns the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It produces pcF and a predicted-taken bit that travels down the pipe beside the instruction. It consumes branch resolution from EX (pcE, pcsrcE, branchE) to train the table and to redirect fetch on a mispredict. It replaces the 1-bit prediction path in front of the datapath's PC mux.

Parameters:
IDX_W, 6, BTB index width; ENTRIES = 2**IDX_W = 64
RESET_PC, 32'h0000_0000, fetch address after reset
ALLOC_CTR, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
stallF  in  1  hazard unit stall; hold pcF
pcF  out  32  current fetch address
predTakenF  out  1  BTB hit and counter MSB set
predTargetF  out  32  BTB target for pcF (0 when no hit)
updEn  in  1  EX-stage branch resolves this cycle (branchE)
updPc  in  32  PC of resolving branch (pcE)
updTaken  in  1  actual outcome (pcsrcE)
updTarget  in  32  actual branch target
mispredict  in  1  EX detected wrong prediction; flush and redirect
redirectPc  in  32  correct next PC on mispredict

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high, port name reset.
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. Each entry holds {valid, tag, target[31:2], ctr[1:0]}.
- Lookup is combinational on pcF.
  - hit = valid & (tag == pcF tag).
  - predTakenF = hit & ctr[1].
  - predTargetF = hit ? {target, 2'b00} : 0.
- Next-PC priority, registered at the posedge:
  - reset -> RESET_PC
  - mispredict -> redirectPc (overrides stallF)
  - stallF -> hold
  - predTakenF -> predTargetF
  - otherwise -> pcF + 4 (32-bit, wraps from 0xFFFF_FFFC to 0)
- Update on updEn, at the posedge, entry = index(updPc):
  - Tag hit: ctr saturates up if updTaken (max 2'b11), down otherwise (min 2'b00). If updTaken, target <= updTarget.
  - Tag miss, updTaken: allocate. valid=1, tag, target written, ctr=ALLOC_CTR.
  - Tag miss, not taken: no change.
- Same-index lookup and update in one cycle: lookup returns the pre-update contents; the new value is visible next cycle.
- Update happens regardless of stallF and mispredict.
- Reset: pcF=RESET_PC. All valid bits cleared in the same cycle, so predTakenF=0 and predTargetF=0 the cycle after reset. Tag, target and ctr are not reset.
- Reset mid-update: reset wins. No table write commits that cycle.
- Latency: the prediction is available in the same cycle as pcF. Redirect takes effect on the next pcF, giving 1 bubble beyond the EX flush.

Optional Feature:
FETCH_STATS_EN. When defined, adds three output ports, each 32-bit and saturating at 32'hFFFF_FFFF, all cleared by reset:
- statLookups: +1 per cycle with !stallF
- statPredTaken: +1 per cycle with predTakenF & !stallF
- statMispredicts: +1 per mispredict
When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - ctr_t (2-bit counter type)
  - constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3
  - DEFAULT_RESET_PC
  - btb_entry_t struct
  - sat_inc / sat_dec functions
- One sub-module, btb_table: entry storage, combinational read port, one synchronous write port, valid-clear on reset.
- fetch_predictor keeps the PC register, the next-PC mux and the optional stats counters.

Test Plan:
- Reset, then 3 cycles with no stall -> pcF sequence 0x0, 0x4, 0x8. predTakenF=0 throughout.
- Update updPc=0x40, updTaken=1, updTarget=0x100 -> entry allocated with ctr=2'b10. When pcF next reaches 0x40: predTakenF=1, predTargetF=0x100, and the following pcF is 0x100.
- Same entry, updTaken=0 twice -> ctr goes 2'b10, 2'b01, 2'b00. At pcF=0x40 predTakenF=0. A third not-taken update leaves ctr at 2'b00; 3 taken updates reach 2'b11 and a 4th stays at 2'b11.
- Alias: an entry at 0x40 exists; update updPc=0x140 (same index, different tag), taken, target 0x200 -> entry replaced. At pcF=0x40 hit=0.
- stallF=1 and mispredict=1 with redirectPc=0x80 in the same cycle -> pcF=0x80 next cycle. With stallF alone, pcF is held for 2 cycles.
- Reset asserted while updEn=1 with a valid entry present -> after reset, pcF=0 and predTakenF=0 for every address. With FETCH_STATS_EN defined, all stats read 0.
